i2s_src_mixer_sched: RTL and testbench
======================================

Name: i2s_src_mixer_sched

Overview:
- Frame-rate scheduler and mixer that shares the I2S serializer among NSRC audio requesters.
- On each frame request from the serializer, it visits every enabled source in turn and pops one left/right sample pair per source over a valid/ready handshake.
- Mixes the popped samples with saturation and presents one stable stereo pair to the serializer's left_chan/right_chan inputs.
- Sits between the core audio producers and the I2S transmitter; runs entirely in the clk domain.

Parameters:
- AUDIO_DW, 16, sample width in bits (signed two's complement); matches the serializer.
- NSRC, 4, number of requesters, 1..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_req  in  1  one-cycle pulse from the serializer when it latches a new L/R pair
- src_en  in  NSRC  per-source enable mask; sampled once per frame at frame_req
- src_valid  in  NSRC  source i has a sample pair available
- src_ready  out  NSRC  pop strobe, one-hot, at most one bit high per cycle
- src_left  in  NSRC*AUDIO_DW  packed left samples; source i occupies bits [i*DW +: DW]
- src_right  in  NSRC*AUDIO_DW  packed right samples, same packing
- left_chan  out  AUDIO_DW  mixed left output, held between frames
- right_chan  out  AUDIO_DW  mixed right output, held between frames
- mix_done  out  1  one-cycle pulse when left_chan/right_chan update
- underrun  out  NSRC  sticky per-source underrun flags
- overrun  out  1  sticky: frame_req arrived while a mix was in progress
- clr_flags  in  1  clears underrun and overrun; if an event occurs in the same cycle, the event wins

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; accumulators 0; hold registers 0.
- FSM states and transitions:
  - IDLE: on frame_req, latch src_en into en_q, clear accL/accR, set idx=0, go to SCAN.
  - SCAN (one cycle per index, idx = 0..NSRC-1):
    - If en_q[idx]=0: contribute nothing, drive no src_ready.
    - If en_q[idx]=1: drive src_ready[idx]=1 for this cycle only.
    - If src_valid[idx]=1 (pop): add sign-extended src_left/right[idx] to accL/accR and store it in hold_L/R[idx].
    - If src_valid[idx]=0: underrun[idx] is set; contribution per Optional Feature.
    - After idx=NSRC-1, go to SAT.
  - SAT: saturate accL/accR to AUDIO_DW (see arithmetic), go to OUT.
  - OUT: register results into left_chan/right_chan, pulse mix_done, go to IDLE.
- Arithmetic: accumulator width AUDIO_DW+3, signed. Saturate to max 2^(DW-1)-1 and min -2^(DW-1). No scaling applied.
- Latency: frame_req to mix_done is exactly NSRC+2 cycles; outputs are valid from the cycle mix_done is high. For DW=16, NSRC=4 this is 6 cycles, far below any frame period.
- Outputs change only in OUT; they stay stable for the whole frame, so the serializer can latch at any point.
- Handshake: a source must hold data/valid until it sees valid&ready. A source sees ready only in its slot, so there is no backpressure outside that cycle.
- frame_req in a non-IDLE state: ignored, overrun set; the current mix completes normally.
- en_q is all zeros: SCAN passes with no pops; output 0,0 (UNDERRUN_HOLD_EN off) or 0,0 (hold has nothing enabled to repeat); mix_done still pulses.
- reset mid-mix: return to IDLE immediately; src_ready deasserts in the next cycle; a partial mix is discarded.
- src_en changes during a mix: no effect until the next frame_req.

Optional Feature:
- Macro: I2S_MIX_UNDERRUN_HOLD_EN.
- Defined: an underrunning enabled source contributes its last popped sample (hold_L/R[idx]) to the mix.
- Undefined: it contributes 0, and hold registers are not synthesized.
- The underrun flag behaves the same in both builds.

Decomposition:
- Package i2s_mix_pkg: ACC_GUARD=3; state encoding IDLE/SCAN/SAT/OUT; function sat_dw(acc) returning a saturated AUDIO_DW value.
- Sub-module i2s_mix_sat: combinational saturator used twice (L/R); otherwise a single module.

Test Plan:
- NSRC=4, all enabled and valid, L samples 1000,2000,-500,0 -> left_chan=2500 six cycles after frame_req; mix_done pulses once; src_ready one-hot sequence 0001,0010,0100,1000.
- Saturation: all four L=16'h7000 -> left_chan=16'h7FFF; all four R=16'h9000 -> right_chan=16'h8000.
- Underrun: src2 not valid on a frame with prior popped L=300, others L=100 -> underrun=0100; left=600 with HOLD_EN, 300 without; clr_flags -> underrun=0.
- src_en=0101 -> ready pulses only in slots 0 and 2; sources 1/3 never popped; mix is the sum of sources 0 and 2.
- frame_req pulsed again 2 cycles after the first -> overrun=1; single mix_done; result equals the first frame's mix.
- reset asserted in the SCAN cycle for idx=1 -> next cycle src_ready=0, left/right_chan=0, FSM IDLE; a fresh frame_req yields a correct full mix.

Source files
------------

// File: rtl/i2s_mix_pkg.sv
// Shared types and helpers for the I2S source mixer/scheduler.
package i2s_mix_pkg;

  // Guard bits let up to 8 full-scale sources sum without wrapping.
  localparam int unsigned ACC_GUARD = 3;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StSat,
    StOut
  } mix_state_e;

  // Clamp a sign-extended accumulator to the signed range of a dw-bit sample (dw <= 29).
  function automatic logic signed [31:0] sat_dw(input logic signed [31:0] acc,
                                                input int unsigned       dw);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (dw - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (dw - 1));
    if (acc > max_v) begin
      return max_v;
    end else if (acc < min_v) begin
      return min_v;
    end
    return acc;
  endfunction

endpackage

// File: rtl/i2s_mix_sat.sv
// Combinational saturator: AUDIO_DW+ACC_GUARD signed accumulator down to AUDIO_DW.
module i2s_mix_sat
  import i2s_mix_pkg::*;
#(
  parameter int unsigned AUDIO_DW = 16
) (
  input  logic signed [AUDIO_DW+ACC_GUARD-1:0] acc,
  output logic        [AUDIO_DW-1:0]           sat
);

  localparam int unsigned AccW = AUDIO_DW + ACC_GUARD;

  logic signed [31:0] acc_ext;
  logic signed [31:0] sat_full;
  logic               unused_sat_hi;

  assign acc_ext       = {{(32 - AccW){acc[AccW-1]}}, acc};
  assign sat_full      = sat_dw(acc_ext, AUDIO_DW);
  assign sat           = sat_full[AUDIO_DW-1:0];
  // Upper bits are pure sign copies once clamped.
  assign unused_sat_hi = ^sat_full[31:AUDIO_DW];

endmodule

// File: rtl/i2s_src_mixer_sched.sv
// Frame scheduler/mixer in front of the I2S serializer: one pop per enabled source per frame.
// Define I2S_MIX_UNDERRUN_HOLD_EN to repeat a source's last popped sample when it underruns.
module i2s_src_mixer_sched
  import i2s_mix_pkg::*;
#(
  parameter int unsigned AUDIO_DW = 16,
  parameter int unsigned NSRC     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_req,
  input  logic [NSRC-1:0]          src_en,
  input  logic [NSRC-1:0]          src_valid,
  output logic [NSRC-1:0]          src_ready,
  input  logic [NSRC*AUDIO_DW-1:0] src_left,
  input  logic [NSRC*AUDIO_DW-1:0] src_right,
  output logic [AUDIO_DW-1:0]      left_chan,
  output logic [AUDIO_DW-1:0]      right_chan,
  output logic                     mix_done,
  output logic [NSRC-1:0]          underrun,
  output logic                     overrun,
  input  logic                     clr_flags
);

  localparam int unsigned AccW    = AUDIO_DW + ACC_GUARD;
  localparam int unsigned IdxW    = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSRC - 1);

  function automatic logic signed [AccW-1:0] sext(input logic [AUDIO_DW-1:0] x);
    return {{ACC_GUARD{x[AUDIO_DW-1]}}, x};
  endfunction

  mix_state_e                 state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [NSRC-1:0]            en_q, en_d;
  logic signed [AccW-1:0]     acc_l_q, acc_l_d;
  logic signed [AccW-1:0]     acc_r_q, acc_r_d;
  logic [AUDIO_DW-1:0]        left_q, left_d;
  logic [AUDIO_DW-1:0]        right_q, right_d;
  logic                       mix_done_q, mix_done_d;
  logic [NSRC-1:0]            underrun_q, underrun_d;
  logic                       overrun_q, overrun_d;
  logic [AUDIO_DW-1:0]        cur_l, cur_r;
  logic [AUDIO_DW-1:0]        sat_l, sat_r;
`ifdef I2S_MIX_UNDERRUN_HOLD_EN
  logic [NSRC-1:0][AUDIO_DW-1:0] hold_l_q, hold_l_d;
  logic [NSRC-1:0][AUDIO_DW-1:0] hold_r_q, hold_r_d;
`endif

  assign cur_l = src_left[idx_q*AUDIO_DW +: AUDIO_DW];
  assign cur_r = src_right[idx_q*AUDIO_DW +: AUDIO_DW];

  i2s_mix_sat #(.AUDIO_DW(AUDIO_DW)) u_sat_l (.acc(acc_l_q), .sat(sat_l));
  i2s_mix_sat #(.AUDIO_DW(AUDIO_DW)) u_sat_r (.acc(acc_r_q), .sat(sat_r));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    en_d       = en_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    left_d     = left_q;
    right_d    = right_q;
    mix_done_d = 1'b0;
    src_ready  = '0;
    // A same-cycle event overrides the clear because it is applied afterwards.
    underrun_d = clr_flags ? '0 : underrun_q;
    overrun_d  = clr_flags ? 1'b0 : overrun_q;
`ifdef I2S_MIX_UNDERRUN_HOLD_EN
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
`endif

    if (frame_req && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_req) begin
          en_d    = src_en;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (en_q[idx_q]) begin
          src_ready[idx_q] = 1'b1;
          if (src_valid[idx_q]) begin
            acc_l_d = acc_l_q + sext(cur_l);
            acc_r_d = acc_r_q + sext(cur_r);
`ifdef I2S_MIX_UNDERRUN_HOLD_EN
            hold_l_d[idx_q] = cur_l;
            hold_r_d[idx_q] = cur_r;
`endif
          end else begin
            underrun_d[idx_q] = 1'b1;
`ifdef I2S_MIX_UNDERRUN_HOLD_EN
            acc_l_d = acc_l_q + sext(hold_l_q[idx_q]);
            acc_r_d = acc_r_q + sext(hold_r_q[idx_q]);
`endif
          end
        end
        if (idx_q == LastIdx) begin
          state_d = StSat;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StSat: begin
        // Results land on the outputs together with mix_done in StOut.
        left_d     = sat_l;
        right_d    = sat_r;
        mix_done_d = 1'b1;
        state_d    = StOut;
      end
      StOut: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      en_q       <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      left_q     <= '0;
      right_q    <= '0;
      mix_done_q <= 1'b0;
      underrun_q <= '0;
      overrun_q  <= 1'b0;
`ifdef I2S_MIX_UNDERRUN_HOLD_EN
      hold_l_q   <= '0;
      hold_r_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      left_q     <= left_d;
      right_q    <= right_d;
      mix_done_q <= mix_done_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
`ifdef I2S_MIX_UNDERRUN_HOLD_EN
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
`endif
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign mix_done   = mix_done_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_src_mixer_sched.sv
// Randomized bench for i2s_src_mixer_sched against a per-frame arithmetic model of the mix.
module tb_i2s_src_mixer_sched;

  localparam int unsigned DW   = 16;
  localparam int unsigned NSRC = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 frame_req;
  logic                 clr_flags;
  logic [NSRC-1:0]      src_en;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC*DW-1:0]   src_left;
  logic [NSRC*DW-1:0]   src_right;
  logic [DW-1:0]        left_chan;
  logic [DW-1:0]        right_chan;
  logic                 mix_done;
  logic [NSRC-1:0]      underrun;
  logic                 overrun;

  logic [DW-1:0]        l_data [NSRC];
  logic [DW-1:0]        r_data [NSRC];

  // Reference state: last popped sample per source, sticky flags, expected outputs.
  int                   last_l [NSRC];
  int                   last_r [NSRC];
  logic [NSRC-1:0]      und_exp;
  logic                 ovr_exp;
  logic [DW-1:0]        exp_l;
  logic [DW-1:0]        exp_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    src_left  = '0;
    src_right = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_left[i*DW +: DW]  = l_data[i];
      src_right[i*DW +: DW] = r_data[i];
    end
  end

  i2s_src_mixer_sched #(
    .AUDIO_DW(DW),
    .NSRC    (NSRC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_req (frame_req),
    .src_en    (src_en),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_left  (src_left),
    .src_right (src_right),
    .left_chan (left_chan),
    .right_chan(right_chan),
    .mix_done  (mix_done),
    .underrun  (underrun),
    .overrun   (overrun),
    .clr_flags (clr_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] clamp(input int s);
    int max_v;
    int min_v;
    int r;
    max_v = (1 << (DW - 1)) - 1;
    min_v = -(1 << (DW - 1));
    r = (s > max_v) ? max_v : ((s < min_v) ? min_v : s);
    return r[DW-1:0];
  endfunction

  function automatic int sval(input logic [DW-1:0] x);
    logic signed [DW-1:0] t;
    t = x;
    return int'(t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      last_l[i] = 0;
      last_r[i] = 0;
    end
    und_exp = '0;
    ovr_exp = 1'b0;
    exp_l   = '0;
    exp_r   = '0;
  endtask

  // One full frame: frame_req in cycle 0, slots in cycles 1..NSRC, mix_done in cycle NSRC+2.
  task automatic run_frame(input logic [NSRC-1:0] en, input logic [NSRC-1:0] vld,
                           input bit dbl_req, input bit clr1);
    int sum_l;
    int sum_r;
    logic [NSRC-1:0] exp_rdy;
    sum_l = 0;
    sum_r = 0;
    @(posedge clk); #1;
    src_en    = en;
    src_valid = vld;
    frame_req = 1'b1;

    if (clr1) begin
      und_exp = '0;
      ovr_exp = 1'b0;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (en[i]) begin
        if (vld[i]) begin
          sum_l += sval(l_data[i]);
          sum_r += sval(r_data[i]);
          last_l[i] = sval(l_data[i]);
          last_r[i] = sval(r_data[i]);
        end else begin
          und_exp[i] = 1'b1;
`ifdef I2S_MIX_UNDERRUN_HOLD_EN
          sum_l += last_l[i];
          sum_r += last_r[i];
`endif
        end
      end
    end
    if (dbl_req) ovr_exp = 1'b1;
    exp_l = clamp(sum_l);
    exp_r = clamp(sum_r);

    for (int c = 1; c <= NSRC + 2; c++) begin
      @(posedge clk); #1;
      frame_req = (dbl_req && c == 2);
      clr_flags = (clr1 && c == 1);
      src_en    = NSRC'($urandom);
      @(negedge clk);
      exp_rdy = '0;
      if (c <= NSRC) begin
        if (en[c-1]) exp_rdy[c-1] = 1'b1;
      end
      check("src_ready", 32'(src_ready), 32'(exp_rdy));
      check("mix_done", 32'(mix_done), 32'(c == NSRC + 2));
    end
    clr_flags = 1'b0;
    check("left_chan", 32'(left_chan), 32'(exp_l));
    check("right_chan", 32'(right_chan), 32'(exp_r));
    check("underrun", 32'(underrun), 32'(und_exp));
    check("overrun", 32'(overrun), 32'(ovr_exp));
  endtask

  task automatic clear_flags();
    @(posedge clk); #1;
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    und_exp = '0;
    ovr_exp = 1'b0;
    @(negedge clk);
    check("clr_underrun", 32'(underrun), 32'(und_exp));
    check("clr_overrun", 32'(overrun), 32'(ovr_exp));
  endtask

  // Reset lands while slot 1 is being scanned; the partial mix must vanish.
  task automatic reset_mid();
    @(posedge clk); #1;
    src_en    = '1;
    src_valid = '1;
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    model_reset();
    check("rst_src_ready", 32'(src_ready), 32'(0));
    check("rst_left", 32'(left_chan), 32'(exp_l));
    check("rst_right", 32'(right_chan), 32'(exp_r));
    check("rst_mix_done", 32'(mix_done), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(und_exp));
    reset = 1'b0;
  endtask

  task automatic set_data(input int l0, input int l1, input int l2, input int l3,
                          input int r0, input int r1, input int r2, input int r3);
    l_data[0] = DW'(l0); l_data[1] = DW'(l1); l_data[2] = DW'(l2); l_data[3] = DW'(l3);
    r_data[0] = DW'(r0); r_data[1] = DW'(r1); r_data[2] = DW'(r2); r_data[3] = DW'(r3);
  endtask

  initial begin
    reset     = 1'b1;
    frame_req = 1'b0;
    clr_flags = 1'b0;
    src_en    = '0;
    src_valid = '0;
    for (int i = 0; i < NSRC; i++) begin
      l_data[i] = '0;
      r_data[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_left", 32'(left_chan), 32'(0));
    check("reset_right", 32'(right_chan), 32'(0));
    check("reset_mix_done", 32'(mix_done), 32'(0));
    check("reset_ready", 32'(src_ready), 32'(0));
    check("reset_underrun", 32'(underrun), 32'(0));
    check("reset_overrun", 32'(overrun), 32'(0));
    reset = 1'b0;

    set_data(1000, 2000, -500, 0, 10, -20, 30, -40);
    run_frame(4'b1111, 4'b1111, 1'b0, 1'b0);

    set_data(32'h7000, 32'h7000, 32'h7000, 32'h7000, 32'h9000, 32'h9000, 32'h9000, 32'h9000);
    run_frame(4'b1111, 4'b1111, 1'b0, 1'b0);

    set_data(100, 100, 300, 100, 5, 6, 7, 8);
    run_frame(4'b1111, 4'b1111, 1'b0, 1'b0);
    run_frame(4'b1111, 4'b1011, 1'b0, 1'b0);
    clear_flags();

    set_data(111, 2222, 333, 4444, -1, -2, -3, -4);
    run_frame(4'b0101, 4'b1111, 1'b0, 1'b0);
    run_frame(4'b0000, 4'b1111, 1'b0, 1'b0);

    set_data(-7, 8, -9, 10, 1, 2, 3, 4);
    run_frame(4'b1111, 4'b1111, 1'b1, 1'b0);
    clear_flags();

    reset_mid();
    set_data(1000, 2000, -500, 0, 1, 2, 3, 4);
    run_frame(4'b1111, 4'b1111, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        if ($urandom_range(2) == 0) begin
          l_data[i] = DW'($urandom);
          r_data[i] = DW'($urandom);
        end else begin
          l_data[i] = DW'($urandom_range(4000)) - DW'(2000);
          r_data[i] = DW'($urandom_range(4000)) - DW'(2000);
        end
      end
      src_valid = '0;
      run_frame(NSRC'($urandom),
                NSRC'($urandom) | NSRC'($urandom),
                ($urandom_range(9) == 0),
                ($urandom_range(7) == 0));
      if ($urandom_range(19) == 0) clear_flags();
      if ($urandom_range(39) == 0) reset_mid();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
